// File: rtl/mips_register_file.sv
// 32 x DATA_W MIPS register file: one-hot qualified write port, two combinational read ports.
// Optional write-through bypass on the read ports when MIPS_REGFILE_BYPASS_EN is defined.
module mips_register_file #(
  parameter int                DATA_W    = 32,
  parameter int                NREGS     = 32,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NREGS-1:0]  we_onehot,
  input  logic              we_valid,
  input  logic [DATA_W-1:0] pw,
  input  logic [4:0]        ra,
  input  logic [4:0]        rb,
  output logic [DATA_W-1:0] pa,
  output logic [DATA_W-1:0] pb,
  output logic              sel_err,
  output logic [15:0]       wr_count
);

  logic [NREGS-1:0][DATA_W-1:0] regs_q;
  logic [NREGS-1:0][DATA_W-1:0] regs_d;
  logic                         sel_err_q, sel_err_d;
  logic [15:0]                  wr_count_q, wr_count_d;

  logic       sel_single;
  logic       commit;
  logic       illegal;
  logic [4:0] wr_idx;

  // Exactly one bit set: nonzero and clearing the lowest set bit leaves nothing.
  always_comb begin
    sel_single = (|we_onehot) && ((we_onehot & (we_onehot - 1'b1)) == '0);
    commit     = reset_n && we_valid && sel_single;
    illegal    = we_valid && !sel_single;
    wr_idx     = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (we_onehot[i]) wr_idx = i[4:0];
    end
  end

  always_comb begin
    sel_err_d  = sel_err_q | illegal;
    wr_count_d = wr_count_q;
    if (commit && (wr_count_q != 16'hFFFF)) wr_count_d = wr_count_q + 16'd1;
  end

  // R0 never takes a write; its flop is held at zero.
  generate
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg_next
      if (gi == 0) begin : g_zero
        assign regs_d[gi] = '0;
      end else begin : g_gpr
        assign regs_d[gi] = (commit && we_onehot[gi]) ? pw : regs_q[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= (i == 0) ? '0 : RESET_VAL;
      end
      sel_err_q  <= 1'b0;
      wr_count_q <= '0;
    end else begin
      regs_q     <= regs_d;
      sel_err_q  <= sel_err_d;
      wr_count_q <= wr_count_d;
    end
  end

  always_comb begin
    pa = (ra == 5'd0) ? '0 : regs_q[ra];
    pb = (rb == 5'd0) ? '0 : regs_q[rb];
`ifdef MIPS_REGFILE_BYPASS_EN
    if (commit && (wr_idx != 5'd0) && (wr_idx == ra)) pa = pw;
    if (commit && (wr_idx != 5'd0) && (wr_idx == rb)) pb = pw;
`endif
  end

  assign sel_err  = sel_err_q;
  assign wr_count = wr_count_q;

`ifndef MIPS_REGFILE_BYPASS_EN
  logic unused_idx;
  assign unused_idx = ^wr_idx;
`endif

endmodule
